// File: rtl/sqrt_seg_driver.sv
// sqrt_seg_driver
//   Output stage for the pipelined square-root core. A valid delay line follows
//   each operand through the core. The root is captured when it emerges. The
//   captured root is held on a 7-segment digit. The decimal point flashes after
//   each capture, and otherwise shows an optional heartbeat.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   in_valid  high in the cycle an operand enters the sqrt core
//   root_in   sqrt core result, taken from its last stage register
//   hb_en     lets the heartbeat blink dp_out while no flash is running
//   seg_out   {g,f,e,d,c,b,a}, active-high segments, registered
//   dp_out    decimal point, registered
//   root_q    last captured root, registered
//   busy      high while any operand is still in flight in the core
module sqrt_seg_driver #(
  parameter int LATENCY   = 4,
  parameter int FLASH_CYC = 8,
  parameter int HB_BITS   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] root_in,
  input  logic       hb_en,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [3:0] root_q,
  output logic       busy
);

  localparam logic [6:0] SEG_DASH = 7'h40;

  typedef enum logic {
    IDLE,  // nothing captured since reset, digit shows a dash
    SHOW   // digit holds the most recent root
  } state_t;

  state_t               state, state_nxt;
  logic [LATENCY-1:0]   vld;
  logic [7:0]           flash, flash_nxt;
  logic [HB_BITS-1:0]   hb;
  logic                 capture;
  logic [6:0]           seg_nxt;
  logic [3:0]           root_nxt;
  logic                 dp_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // The oldest delay-line slot lines up with the cycle in which root_in
  // carries that operand's result.
  assign capture = vld[LATENCY-1];
  assign busy    = |vld;

  // NOTE: this block gives every output a default before any branch, so
  // each path assigns every signal and no latch is inferred.
  always_comb begin
    state_nxt = state;
    root_nxt  = root_q;
    seg_nxt   = seg_out;
    flash_nxt = (flash != 8'd0) ? flash - 8'd1 : 8'd0;

    case (state)
      IDLE:    seg_nxt = SEG_DASH;
      SHOW:    seg_nxt = seg_out;
      default: seg_nxt = SEG_DASH;
    endcase

    // A capture reloads the flash timer even while it is counting down.
    if (capture) begin
      state_nxt = SHOW;
      root_nxt  = root_in;
      seg_nxt   = hex7(root_in);
      flash_nxt = 8'(FLASH_CYC);
    end

    // The flash takes priority. The heartbeat shows only when no flash will
    // be running after this edge.
    dp_nxt = (flash_nxt != 8'd0) | (hb_en & hb[HB_BITS-1] & (flash_nxt == 8'd0));
  end

  // NOTE: registers use non-blocking assignments, so every flop samples
  // values from before the edge. The delay line shifts correctly in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      vld     <= '0;
      flash   <= 8'd0;
      hb      <= '0;
      root_q  <= 4'd0;
      seg_out <= SEG_DASH;
      dp_out  <= 1'b0;
    end else begin
      vld[0] <= in_valid;
      for (int k = 1; k < LATENCY; k++) vld[k] <= vld[k-1];
      state   <= state_nxt;
      flash   <= flash_nxt;
      hb      <= hb + 1'b1;
      root_q  <= root_nxt;
      seg_out <= seg_nxt;
      dp_out  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_sqrt_seg_driver.sv
// Testbench for sqrt_seg_driver. The reference model keeps a per-cycle record
// of in_valid and rst. An operand entered in cycle c produces a capture at the
// end of cycle c+LAT, unless rst was sampled in any cycle from c to c+LAT. The
// flash and heartbeat timers are modelled as plain integers.
module tb_sqrt_seg_driver;

  localparam int LAT   = 4;
  localparam int FLASH = 8;
  localparam int HBW   = 3;
  localparam int MAXC  = 2048;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] root_in = 4'd0;
  logic       hb_en = 1'b0;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [3:0] root_q;
  logic       busy;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int         cyc = 0;
  bit         vh [MAXC];
  bit         rh [MAXC];
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [6:0] m_seg = 7'h40;
  logic [3:0] m_root = 4'd0;
  logic       m_dp = 1'b0;
  logic       m_busy = 1'b0;
  int         m_flash = 0;
  int         m_hb = 0;

  sqrt_seg_driver #(.LATENCY(LAT), .FLASH_CYC(FLASH), .HB_BITS(HBW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .root_in  (root_in),
    .hb_en    (hb_en),
    .seg_out  (seg_out),
    .dp_out   (dp_out),
    .root_q   (root_q),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
  endtask

  // Returns 1 if rst was sampled in any cycle from 'from' to 'upto'.
  function automatic bit killed(input int from, input int upto);
    for (int i = from; i <= upto; i++) if (rh[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model over one clock edge, using the inputs sampled at it.
  task automatic model_edge();
    bit cap;
    int fl_n;
    vh[cyc] = in_valid;
    rh[cyc] = rst;
    cap = !rst && (cyc >= LAT) && vh[cyc-LAT] && !killed(cyc - LAT, cyc);
    if (rst) begin
      m_seg = 7'h40; m_root = 4'd0; m_dp = 1'b0; m_flash = 0; m_hb = 0;
    end else begin
      fl_n = cap ? FLASH : ((m_flash > 0) ? m_flash - 1 : 0);
      m_dp = (fl_n != 0) || (hb_en && (m_hb >= (1 << (HBW - 1))));
      m_flash = fl_n;
      m_hb = (m_hb + 1) % (1 << HBW);
      if (cap) begin
        m_root = root_in;
        m_seg  = hex_tab[root_in];
      end
    end
    // An operand is in flight if it entered within the last LAT cycles and
    // no reset has hit it since then.
    m_busy = 1'b0;
    for (int k = 0; k < LAT; k++)
      if (cyc - k >= 0 && vh[cyc-k] && !killed(cyc - k, cyc)) m_busy = 1'b1;
    cyc++;
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] rt, input logic he);
    rst = r; in_valid = v; root_in = rt; hb_en = he;
    @(posedge clk);
    model_edge();
    #1;
    check("seg_out", 32'(seg_out), 32'(m_seg));
    check("root_q",  32'(root_q),  32'(m_root));
    check("dp_out",  32'(dp_out),  32'(m_dp));
    check("busy",    32'(busy),    32'(m_busy));
  endtask

  task automatic idle(input int n, input logic he);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'($urandom_range(15)), he);
  endtask

  initial begin
    // Reset for two cycles with in_valid high. No capture may follow.
    step(1'b1, 1'b1, 4'h5, 1'b0);
    step(1'b1, 1'b1, 4'h5, 1'b0);
    check("reset_seg", 32'(seg_out), 32'h40);
    check("reset_busy", 32'(busy), 32'h0);
    idle(6, 1'b0);
    check("reset_no_capture", 32'(seg_out), 32'h40);

    // Single operand whose root is 10.
    step(1'b0, 1'b1, 4'h0, 1'b0);
    idle(3, 1'b0);
    step(1'b0, 1'b0, 4'hA, 1'b0);
    check("single_root", 32'(root_q), 32'hA);
    check("single_seg", 32'(seg_out), 32'h77);
    check("single_dp", 32'(dp_out), 32'h1);
    idle(12, 1'b0);

    // Four back-to-back operands.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'($urandom_range(15)), 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 4'd1, 1'b0);
    step(1'b0, 1'b0, 4'd9, 1'b0);
    step(1'b0, 1'b0, 4'd11, 1'b0);
    check("stream_last_seg", 32'(seg_out), 32'h7C);
    idle(12, 1'b0);

    // Operands in cycles 0 and 2. The value of root_in in cycle 5 must be ignored.
    step(1'b0, 1'b1, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h3, 1'b0);
    step(1'b0, 1'b0, 4'hF, 1'b0);
    check("gap_ignored", 32'(root_q), 32'h3);
    step(1'b0, 1'b0, 4'h5, 1'b0);
    idle(10, 1'b0);

    // Reset hits an operand that is still in flight.
    step(1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h7, 1'b0);
    step(1'b1, 1'b0, 4'h7, 1'b0);
    step(1'b0, 1'b0, 4'h7, 1'b0);
    step(1'b0, 1'b0, 4'h7, 1'b0);
    check("midflight_seg", 32'(seg_out), 32'h40);
    idle(4, 1'b0);

    // Heartbeat on, heartbeat off, then a capture while the heartbeat is running.
    idle(20, 1'b1);
    idle(8, 1'b0);
    step(1'b0, 1'b1, 4'h0, 1'b1);
    idle(3, 1'b1);
    step(1'b0, 1'b0, 4'h2, 1'b1);
    idle(16, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(31) == 0), 1'($urandom_range(1)), 4'($urandom_range(15)),
           ($urandom_range(3) != 0));
    idle(LAT + FLASH + 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
